// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the unified memory port arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_kill;
   logic                  if_ack;
   logic [DATA_WIDTH-1:0] if_rdata;

   logic                  dm_req;
   logic                  dm_we;
   logic [3:0]            dm_be;
   logic [ADDR_WIDTH-1:0] dm_addr;
   logic [DATA_WIDTH-1:0] dm_wdata;
   logic                  dm_ack;
   logic [DATA_WIDTH-1:0] dm_rdata;

   logic                  mem_en;
   logic                  mem_we;
   logic [3:0]            mem_be;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic                  busy;

   modport slave (
      input  if_req, if_addr, if_kill,
      output if_ack, if_rdata,
      input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      output dm_ack, dm_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output if_req, if_addr, if_kill,
      input  if_ack, if_rdata,
      output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      input  dm_ack, dm_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory: fixed-latency
// issue/wait/response sequencing, data priority with a fetch starvation guard.
module mem_port_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int MEM_LAT       = 2,
   parameter int DM_MAX_CONSEC = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int LAT_W = $clog2(MEM_LAT + 1);
   localparam int SC_W  = $clog2(DM_MAX_CONSEC + 1);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
   localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(DM_MAX_CONSEC);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic                  owner_dm_q, owner_dm_d;
   logic                  owner_we_q, owner_we_d;
   logic                  killed_q, killed_d;
   logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
   logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [3:0]            mem_be_q, mem_be_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  if_ack_q, if_ack_d;
   logic                  dm_ack_q, dm_ack_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
   logic                  busy_q, busy_d;
   logic                  grant_dm;
   logic                  kill_hit;

   always_comb begin
      state_d      = state_q;
      owner_dm_d   = owner_dm_q;
      owner_we_d   = owner_we_q;
      killed_d     = killed_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_be_d     = 4'h0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_ack_d     = 1'b0;
      dm_ack_d     = 1'b0;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;
      busy_d       = busy_q;
      grant_dm     = 1'b0;
      // A kill only matters while a fetch owns the port.
      kill_hit     = bus.if_kill && !owner_dm_q;

      case (state_q)
         S_IDLE: begin
            if (bus.if_req || bus.dm_req) begin
               grant_dm   = bus.dm_req && !(bus.if_req && (starve_cnt_q == SC_MAX));
               state_d    = S_ISSUE;
               busy_d     = 1'b1;
               mem_en_d   = 1'b1;
               owner_dm_d = grant_dm;
               killed_d   = 1'b0;
               if (grant_dm) begin
                  owner_we_d  = bus.dm_we;
                  mem_we_d    = bus.dm_we;
                  mem_be_d    = bus.dm_be;
                  mem_addr_d  = bus.dm_addr;
                  mem_wdata_d = bus.dm_wdata;
                  if (!bus.if_req)
                     starve_cnt_d = '0;
                  else if (starve_cnt_q != SC_MAX)
                     starve_cnt_d = starve_cnt_q + 1'b1;
               end else begin
                  owner_we_d   = 1'b0;
                  mem_be_d     = 4'hF;
                  mem_addr_d   = bus.if_addr;
                  mem_wdata_d  = '0;
                  starve_cnt_d = '0;
               end
            end
         end
         S_ISSUE: begin
            lat_cnt_d = LAT_LOAD;
            state_d   = S_WAIT;
            if (kill_hit)
               killed_d = 1'b1;
         end
         S_WAIT: begin
            lat_cnt_d = lat_cnt_q - 1'b1;
            if (kill_hit)
               killed_d = 1'b1;
            if (lat_cnt_q == LAT_W'(1)) begin
               // The memory cycle always runs to completion; a killed fetch just drops its reply.
               if (!owner_dm_q && (killed_q || bus.if_kill)) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_RESP;
                  if (owner_dm_q) begin
                     dm_ack_d = 1'b1;
                     if (!owner_we_q)
                        dm_rdata_d = bus.mem_rdata;
                  end else begin
                     if_ack_d   = 1'b1;
                     if_rdata_d = bus.mem_rdata;
                  end
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_dm_q   <= 1'b0;
         owner_we_q   <= 1'b0;
         killed_q     <= 1'b0;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= 4'h0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_ack_q     <= 1'b0;
         dm_ack_q     <= 1'b0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_dm_q   <= owner_dm_d;
         owner_we_q   <= owner_we_d;
         killed_q     <= killed_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_be_q     <= mem_be_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_ack_q     <= if_ack_d;
         dm_ack_q     <= dm_ack_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.if_ack    = if_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural fixed-latency memory, expectation queues
// for memory strobes and acks, a vector table plus directed multi-cycle sequences.
module tb_mem_port_arbiter;
   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int LAT  = 2;
   localparam int MAXC = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

   mem_port_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LAT(LAT), .DM_MAX_CONSEC(MAXC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: unwritten words read as a fixed pattern, two preloaded words.
   logic [31:0] memw [1024];
   bit          written [1024];
   logic [31:0] pipe_d [LAT];
   bit          pipe_v [LAT];

   function automatic logic [31:0] base_word(logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      if (a == 32'h200) return 32'hCAFEF00D;
      return 32'h5A5A0000 | {20'h0, a[11:0]};
   endfunction

   function automatic logic [31:0] rd_word(logic [31:0] a);
      return written[a[11:2]] ? memw[a[11:2]] : base_word(a);
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) begin
         memw[bus.mem_addr[11:2]]    <= merge(rd_word(bus.mem_addr), bus.mem_wdata, bus.mem_be);
         written[bus.mem_addr[11:2]] <= 1'b1;
      end
      pipe_v[0] <= bus.mem_en && !bus.mem_we;
      pipe_d[0] <= rd_word(bus.mem_addr);
      for (int i = 1; i < LAT; i++) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_d[i] <= pipe_d[i-1];
      end
   end
   assign bus.mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hBAD0BAD0;

   // Expectation queues
   typedef struct {
      int          cyc;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mexp_t;
   typedef struct {
      int          cyc;
      bit          is_dm;
      logic [31:0] rdata;
   } aexp_t;
   mexp_t mem_q[$];
   aexp_t ack_q[$];
   mexp_t m_obs;
   aexp_t a_obs;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_txn(bit is_dm, logic we, logic [3:0] be, logic [31:0] addr,
                           logic [31:0] wdata, logic [31:0] rdata, int mcyc, bit acked);
      mem_q.push_back('{mcyc, is_dm ? we : 1'b0, is_dm ? be : 4'hF, addr, wdata});
      if (acked) ack_q.push_back('{mcyc + LAT + 1, is_dm, rdata});
   endtask

   task automatic check_ack(bit is_dm, logic [31:0] rd);
      if (ack_q.size() == 0) begin
         chk(is_dm ? "spurious_dm_ack" : "spurious_if_ack", 1, 0);
      end else begin
         a_obs = ack_q.pop_front();
         chk("ack_owner", 64'(is_dm), 64'(a_obs.is_dm));
         chk("ack_cycle", 64'(cyc), 64'(a_obs.cyc));
         chk("ack_rdata", 64'(rd), 64'(a_obs.rdata));
         $display("txn ack %s cycle %0d rdata %08h", is_dm ? "DM" : "IF", cyc, rd);
      end
   endtask

   // Monitor, sampling on the falling edge
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (bus.mem_en) begin
            if (mem_q.size() == 0) begin
               chk("spurious_mem_en", 1, 0);
            end else begin
               m_obs = mem_q.pop_front();
               chk("mem_en_cycle", 64'(cyc), 64'(m_obs.cyc));
               chk("mem_we", 64'(bus.mem_we), 64'(m_obs.we));
               chk("mem_be", 64'(bus.mem_be), 64'(m_obs.be));
               chk("mem_addr", 64'(bus.mem_addr), 64'(m_obs.addr));
               if (m_obs.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_obs.wdata));
               chk("busy_issue", 64'(bus.busy), 1);
            end
         end else begin
            chk("mem_we_be_idle", {bus.mem_we, bus.mem_be}, 0);
         end
         if (bus.if_ack) check_ack(1'b0, bus.if_rdata);
         if (bus.dm_ack) check_ack(1'b1, bus.dm_rdata);
      end
   end

   task automatic wait_ack(bit is_dm, int budget);
      int n;
      n = 0;
      while (n < budget) begin
         @(negedge clk);
         if (is_dm ? bus.dm_ack : bus.if_ack) break;
         n++;
      end
      if (n >= budget) chk(is_dm ? "dm_ack_timeout" : "if_ack_timeout", 0, 1);
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_ctrl"}, {bus.if_ack, bus.dm_ack, bus.mem_en, bus.mem_we, bus.mem_be, bus.busy}, 0);
      chk({tag, "_if_rdata"}, 64'(bus.if_rdata), 0);
      chk({tag, "_dm_rdata"}, 64'(bus.dm_rdata), 0);
      chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 0);
      chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 0);
   endtask

   typedef struct {
      bit          is_dm;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs[10];

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      int acks;
      int n;
      logic [31:0] da, ia;

      // Store vectors expect dm_rdata to keep the previous load value.
      vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h2000, 32'h0,       32'h5A5A0000};
      vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h40, 32'h11223344,  32'h5A5A0000};
      vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h40, 32'h0,         32'h5A5A3344};
      vecs[4] = '{1'b0, 1'b0, 4'hF, 32'h200, 32'h0,        32'hCAFEF00D};
      vecs[5] = '{1'b1, 1'b1, 4'hC, 32'h44, 32'hAABBCCDD,  32'h5A5A3344};
      vecs[6] = '{1'b1, 1'b0, 4'hF, 32'h44, 32'h0,         32'hAABB0044};
      vecs[7] = '{1'b0, 1'b0, 4'hF, 32'h44, 32'h0,         32'hAABB0044};
      vecs[8] = '{1'b1, 1'b1, 4'hF, 32'h48, 32'h01020304,  32'hAABB0044};
      vecs[9] = '{1'b0, 1'b0, 4'hF, 32'h48, 32'h0,         32'h01020304};

      bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = 4'h0;
      bus.dm_addr = '0;  bus.dm_wdata = '0;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Single-requester vectors
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         c = cyc;
         if (vecs[i].is_dm) begin
            bus.dm_req = 1'b1; bus.dm_we = vecs[i].we; bus.dm_be = vecs[i].be;
            bus.dm_addr = vecs[i].addr; bus.dm_wdata = vecs[i].wdata;
         end else begin
            bus.if_req = 1'b1; bus.if_addr = vecs[i].addr;
         end
         push_txn(vecs[i].is_dm, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_rdata, c + 1, 1'b1);
         wait_ack(vecs[i].is_dm, 20);
         bus.if_req = 1'b0;
         bus.dm_req = 1'b0;
      end

      // Simultaneous requests: data wins, fetch follows after the RESP/IDLE gap.
      @(negedge clk);
      c = cyc;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h2000;
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      push_txn(1'b1, 1'b0, 4'hF, 32'h2000, 32'h0, 32'h5A5A0000, c + 1, 1'b1);
      push_txn(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, c + 6, 1'b1);
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         if (bus.dm_ack) bus.dm_req = 1'b0;
         if (bus.if_ack) break;
         n++;
      end
      if (n >= 40) chk("both_if_ack_timeout", 0, 1);
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;

      // Starvation guard: both held, expect D D D D I D D D D I.
      @(negedge clk);
      c = cyc;
      da = 32'h500; ia = 32'h600;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = da;
      bus.if_req = 1'b1; bus.if_addr = ia;
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9) begin
            push_txn(1'b0, 1'b0, 4'hF, ia, 32'h0, base_word(ia), c + 1 + 5 * k, 1'b1);
            ia = ia + 4;
         end else begin
            push_txn(1'b1, 1'b0, 4'hF, da, 32'h0, base_word(da), c + 1 + 5 * k, 1'b1);
            da = da + 4;
         end
      end
      acks = 0;
      n = 0;
      while (acks < 10 && n < 200) begin
         @(negedge clk);
         if (bus.dm_ack) begin bus.dm_addr = bus.dm_addr + 4; acks++; end
         if (bus.if_ack) begin bus.if_addr = bus.if_addr + 4; acks++; end
         n++;
      end
      chk("starve_ack_count", 64'(acks), 10);
      bus.dm_req = 1'b0;
      bus.if_req = 1'b0;

      // Kill during WAIT, then refetch from the redirected address.
      @(negedge clk);
      c = cyc;
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      push_txn(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 32'h0, c + 1, 1'b0);
      repeat (2) @(negedge clk);
      bus.if_kill = 1'b1; bus.if_addr = 32'h200;
      push_txn(1'b0, 1'b0, 4'hF, 32'h200, 32'h0, 32'hCAFEF00D, c + 5, 1'b1);
      @(negedge clk);
      bus.if_kill = 1'b0;
      wait_ack(1'b0, 20);
      bus.if_req = 1'b0;

      // Reset in WAIT aborts the load; the next request runs normally.
      @(negedge clk);
      c = cyc;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h700;
      push_txn(1'b1, 1'b0, 4'hF, 32'h700, 32'h0, 32'h0, c + 1, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bus.dm_req = 1'b0;
      @(negedge clk);
      check_all_zero("abort");
      rst = 1'b0;
      @(negedge clk);
      c = cyc;
      bus.dm_req = 1'b1; bus.dm_addr = 32'h704;
      push_txn(1'b1, 1'b0, 4'hF, 32'h704, 32'h0, 32'h5A5A0704, c + 1, 1'b1);
      wait_ack(1'b1, 20);
      bus.dm_req = 1'b0;

      repeat (6) @(negedge clk);
      chk("mem_q_drained", 64'(mem_q.size()), 0);
      chk("ack_q_drained", 64'(ack_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
